// File: rtl/aes_mix_columns.sv
// -----------------------------------------------------------------------------
// aes_mix_columns
//
// Column-serial AES MixColumns / InvMixColumns stage.  A 128-bit state is
// accepted in IDLE, its four columns are pushed one per cycle through a single
// shared GF(2^8) column datapath, and the finished state is presented in DONE
// under a valid/ready handshake.
//
// Byte layout: byte i = data[8i+7:8i]; column c = bytes 4c..4c+3, with byte 4c
// holding row 0 of that column.
//
// Build option:
//   MIXCOL_INV_EN  defined   -> encrypt=0 selects InvMixColumns.
//                  undefined -> the inverse datapath is not built; encrypt is
//                               ignored and the forward transform (or bypass)
//                               is always applied.  The port list is unchanged.
// -----------------------------------------------------------------------------

`ifndef DATA_SIZE
`define DATA_SIZE 128
`endif

module aes_mix_columns (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`DATA_SIZE-1:0]  data_in,
    input  logic                   encrypt,
    input  logic                   bypass,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [`DATA_SIZE-1:0]  data_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
    // -------------------------------------------------------------------------

    // Multiply a field element by x (i.e. by 02).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] shifted;
        shifted = {b[6:0], 1'b0};
        if (b[7]) begin
            xtime = shifted ^ 8'h1b;
        end else begin
            xtime = shifted;
        end
    endfunction

    // Forward MixColumns on one column: b_r = 2a_r ^ 3a_(r+1) ^ a_(r+2) ^ a_(r+3).
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        // 3a = 2a ^ a, so each row is xtime(a_r ^ a_(r+1)) ^ a_(r+1) ^ a_(r+2) ^ a_(r+3)
        b0 = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
        b1 = xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0;
        b2 = xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1;
        b3 = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
        mix_fwd = {b3, b2, b1, b0};
    endfunction

`ifdef MIXCOL_INV_EN
    // Multiply by 0E, 0B, 0D, 09 built from x2/x4/x8 partial products.
    function automatic logic [7:0] mul_0e(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        mul_0e = x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        mul_0b = x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] a);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        mul_0d = x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        mul_09 = x8 ^ a;
    endfunction

    // InvMixColumns on one column: b_r = 0E a_r ^ 0B a_(r+1) ^ 0D a_(r+2) ^ 09 a_(r+3).
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
        b1 = mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3) ^ mul_09(a0);
        b2 = mul_0e(a2) ^ mul_0b(a3) ^ mul_0d(a0) ^ mul_09(a1);
        b3 = mul_0e(a3) ^ mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2);
        mix_inv = {b3, b2, b1, b0};
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_r;
    logic [1:0]              col_cnt_r;
    logic [`DATA_SIZE-1:0]   data_r;
    logic                    byp_r;
    logic [`DATA_SIZE-1:0]   result_r;
    logic                    out_valid_r;
    logic                    in_ready_r;
`ifdef MIXCOL_INV_EN
    logic                    enc_r;
`else
    // encrypt has no function in a forward-only build; keep it visibly consumed.
    logic                    unused_encrypt_s;
    assign unused_encrypt_s = encrypt;
`endif

    logic [31:0]             col_in_s;
    logic [31:0]             col_out_s;

    // Select the column currently being processed from the latched state.
    always_comb begin
        col_in_s = 32'h0000_0000;
        case (col_cnt_r)
            2'd0:    col_in_s = data_r[31:0];
            2'd1:    col_in_s = data_r[63:32];
            2'd2:    col_in_s = data_r[95:64];
            2'd3:    col_in_s = data_r[127:96];
            default: col_in_s = data_r[31:0];
        endcase
    end

    // Shared column datapath: bypass wins, then direction selects the transform.
    always_comb begin
        col_out_s = col_in_s;
        if (byp_r) begin
            col_out_s = col_in_s;
        end
`ifdef MIXCOL_INV_EN
        else if (enc_r) begin
            col_out_s = mix_fwd(col_in_s);
        end else begin
            col_out_s = mix_inv(col_in_s);
        end
`else
        else begin
            col_out_s = mix_fwd(col_in_s);
        end
`endif
    end

    // Control FSM, input latch and result register; reset beats any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            col_cnt_r   <= 2'd0;
            data_r      <= {`DATA_SIZE{1'b0}};
            byp_r       <= 1'b0;
            result_r    <= {`DATA_SIZE{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
`ifdef MIXCOL_INV_EN
            enc_r       <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        data_r     <= data_in;
                        byp_r      <= bypass;
`ifdef MIXCOL_INV_EN
                        enc_r      <= encrypt;
`endif
                        col_cnt_r  <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end else begin
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    case (col_cnt_r)
                        2'd0:    result_r[31:0]   <= col_out_s;
                        2'd1:    result_r[63:32]  <= col_out_s;
                        2'd2:    result_r[95:64]  <= col_out_s;
                        2'd3:    result_r[127:96] <= col_out_s;
                        default: result_r[31:0]   <= col_out_s;
                    endcase
                    col_cnt_r <= col_cnt_r + 2'd1;
                    if (col_cnt_r == 2'd3) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= BUSY;
                    end
                end
                DONE: begin
                    // result_r is left untouched so data_out holds after the handshake.
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_cnt_r   <= 2'd0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = result_r;

endmodule

// File: tb/tb_aes_mix_columns.sv
// -----------------------------------------------------------------------------
// tb_aes_mix_columns
//
// Directed bench for aes_mix_columns.  Expected states are computed by a
// generic shift-and-add GF(2^8) matrix model, pushed to a scoreboard queue when
// a state is offered, and popped when out_valid appears.  Honours the
// MIXCOL_INV_EN build option the same way the design does.
// -----------------------------------------------------------------------------

`ifndef DATA_SIZE
`define DATA_SIZE 128
`endif

module tb_aes_mix_columns;

`ifdef MIXCOL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [`DATA_SIZE-1:0] data_in;
    logic                  encrypt;
    logic                  bypass;
    logic                  in_valid;
    logic                  in_ready;
    logic [`DATA_SIZE-1:0] data_out;
    logic                  out_valid;
    logic                  out_ready;

    int compared;
    int mismatched;
    int cyc;
    logic [127:0] exp_q[$];

    aes_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .encrypt   (encrypt),
        .bypass    (bypass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Generic GF(2^8) multiply, modulus 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference model: circulant matrix product per column.
    function automatic logic [127:0] model(input logic [127:0] d, input logic enc, input logic byp);
        logic [7:0]   m [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (byp) return d;
        if (enc || !INV_EN) begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end else begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(m[(k - row + 4) % 4], d[32*c + 8*k +: 8]);
                end
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer a state from IDLE; the next edge is the accept edge.  Inputs are
    // then scrambled to show they are ignored after the accept.
    task automatic send(input logic [127:0] d, input logic enc, input logic byp);
        data_in  = d;
        encrypt  = enc;
        bypass   = byp;
        in_valid = 1'b1;
        exp_q.push_back(model(d, enc, byp));
        tick();
        check("accept_in_ready_low", {127'h0, in_ready}, 128'h0);
        in_valid = 1'b0;
        data_in  = rand128();
        encrypt  = ~enc;
        bypass   = ~byp;
    endtask

    // Wait (bounded) for out_valid after an accept, check latency, pop and compare.
    task automatic collect(input string tag, input logic [127:0] const_exp, input logic use_const);
        int n;
        logic [127:0] e;
        n = 0;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'd4);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, data_out, e);
        end
        if (use_const) check({tag, "_vector"}, data_out, const_exp);
    endtask

    // Complete the output handshake and check return to IDLE with data held.
    task automatic release_out(input string tag);
        logic [127:0] held;
        held = data_out;
        out_ready = 1'b1;
        tick();
        check({tag, "_ov_low"}, {127'h0, out_valid}, 128'h0);
        check({tag, "_ir_high"}, {127'h0, in_ready}, 128'h1);
        check({tag, "_held"}, data_out, held);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        logic [127:0] inv_in;
        logic [127:0] inv_exp;
        int prev_acc;
        int n;

        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        rst        = 1'b1;
        data_in    = 128'h0;
        encrypt    = 1'b1;
        bypass     = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", {127'h0, in_ready}, 128'h1);
        check("reset_out_valid", {127'h0, out_valid}, 128'h0);
        check("reset_data_out", data_out, 128'h0);

        // Forward known-answer vector
        d = 128'h01010101_01010101_01010101_455313db;
        send(d, 1'b1, 1'b0);
        collect("fwd", 128'h01010101_01010101_01010101_bca14d8e, 1'b1);
        release_out("fwd_rel");

        // Inverse known-answer vector (forward result if inverse not built)
        inv_in  = 128'h01010101_01010101_9d58dc9f_bca14d8e;
        inv_exp = INV_EN ? 128'h01010101_01010101_5c220af2_455313db : model(inv_in, 1'b1, 1'b0);
        send(inv_in, 1'b0, 1'b0);
        collect("inv", inv_exp, 1'b1);
        release_out("inv_rel");

        // Bypass, forward and inverse selected: bypass always wins
        d = rand128();
        send(d, 1'b1, 1'b1);
        collect("byp_enc", d, 1'b1);
        release_out("byp_enc_rel");
        d = rand128();
        send(d, 1'b0, 1'b1);
        collect("byp_dec", d, 1'b1);
        release_out("byp_dec_rel");

        // Random inverse/forward mix
        for (int i = 0; i < 3; i++) begin
            send(rand128(), 1'(i % 2), 1'b0);
            collect("rand", 128'h0, 1'b0);
            release_out("rand_rel");
        end

        // Backpressure: hold DONE for 10 cycles with a new state offered
        send(rand128(), 1'b1, 1'b0);
        collect("bp", 128'h0, 1'b0);
        held     = data_out;
        data_in  = rand128();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable", data_out, held);
            check("bp_in_ready", {127'h0, in_ready}, 128'h0);
            check("bp_out_valid", {127'h0, out_valid}, 128'h1);
        end
        in_valid = 1'b0;
        release_out("bp_rel");

        // Reset during the second BUSY cycle discards the state
        send(rand128(), 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_out_valid", {127'h0, out_valid}, 128'h0);
        check("abort_data_out", data_out, 128'h0);
        check("abort_in_ready", {127'h0, in_ready}, 128'h1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("abort_no_pulse", 128'(n), 128'd0);

        // Reset has priority over a simultaneous accept
        data_in  = rand128();
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_in_ready", {127'h0, in_ready}, 128'h1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("rst_prio_no_output", 128'(n), 128'd0);

        // Back-to-back streaming with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        encrypt   = 1'b1;
        bypass    = 1'b0;
        d         = rand128();
        data_in   = d;
        exp_q.push_back(model(d, 1'b1, 1'b0));
        prev_acc  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i > 0) check("stream_spacing", 128'(cyc - prev_acc), 128'd6);
            prev_acc = cyc;
            if (i < 7) begin
                d       = rand128();
                data_in = d;
                exp_q.push_back(model(d, 1'b1, 1'b0));
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 12) begin
                tick();
                n++;
            end
            check("stream_latency", 128'(n), 128'd4);
            if (exp_q.size() == 0) begin
                check("stream_queue_empty", 128'd0, 128'd1);
            end else begin
                check("stream_data", data_out, exp_q.pop_front());
            end
            tick();
            check("stream_idle", {127'h0, in_ready}, 128'h1);
        end
        out_ready = 1'b0;
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns.md
AES_MIX_COLUMNS -- requirements
Module: aes_mix_columns

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port data_in, input, `DATA_SIZE (128) bits: state from aes_shift_rows; byte i = data_in[8i+7:8i]; column c = bytes 4c..4c+3, byte 4c = row 0.
REQ-004 SHALL have port encrypt, input, 1 bit: 1 = MixColumns, 0 = InvMixColumns; sampled at accept.
REQ-005 SHALL have port bypass, input, 1 bit: 1 = pass state unchanged (final round); sampled at accept.
REQ-006 SHALL have port in_valid, input, 1 bit: data_in/encrypt/bypass valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-008 SHALL have port data_out, output, `DATA_SIZE bits: result, same byte/column layout as data_in.
REQ-009 SHALL have port out_valid, output, 1 bit: data_out valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts data_out.

Function
REQ-011 SHALL implement three states: IDLE, BUSY, DONE; 2-bit column counter col_cnt.
REQ-012 SHALL drive in_ready=1 only in IDLE; accept occurs on an edge with in_valid && in_ready.
REQ-013 On accept SHALL latch data_in, encrypt, bypass into internal registers, clear col_cnt, and enter BUSY; later changes on these inputs SHALL be ignored until the next accept.
REQ-014 In BUSY, each cycle SHALL process the column col_cnt (one column/cycle, single shared GF(2^8) datapath), write it into the result register, and increment col_cnt.
REQ-015 Forward column (a0..a3) SHALL give b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4, xtime reduction polynomial 0x11B.
REQ-016 Inverse column SHALL give b_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3).
REQ-017 With latched bypass=1 the column SHALL be copied unchanged; timing SHALL be identical to the non-bypass case.
REQ-018 When col_cnt=3 is processed (wrap 3->0), the FSM SHALL enter DONE; out_valid SHALL rise 4 edges after the accept edge.
REQ-019 In DONE, out_valid=1 and data_out SHALL remain stable until an edge with out_ready=1, then the FSM SHALL return to IDLE (out_valid=0) and hold data_out.
REQ-020 in_valid asserted during BUSY/DONE SHALL NOT be accepted; the upstream holds it; maximum throughput is one state per 6 cycles with out_ready tied high.
REQ-021 out_ready asserted outside DONE SHALL have no effect.
REQ-022 Latched encrypt=0 and bypass=1 together SHALL yield bypass (bypass has priority).

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, col_cnt=0, data_out=0, out_valid=0, in_ready=1 after that edge, from any state.
REQ-024 Reset mid-BUSY or in DONE SHALL discard the in-flight state without emitting it; rst SHALL take priority over an accept on the same edge.

Configuration
REQ-025 Macro MIXCOL_INV_EN defined: encrypt input SHALL be honoured per REQ-016.
REQ-026 Macro MIXCOL_INV_EN undefined: the inverse datapath SHALL NOT be synthesised; encrypt SHALL be ignored and the block SHALL always apply forward MixColumns (or bypass); port list SHALL be unchanged.

Verification
REQ-027 Bench SHALL cover forward: column 0 = db 13 53 45, others 01 01 01 01, encrypt=1 -> column 0 = 8e 4d a1 bc, others 01 01 01 01, out_valid on 4th edge after accept.
REQ-028 Bench SHALL cover inverse: column 0 = 8e 4d a1 bc, column 1 = 9f dc 58 9d, encrypt=0 (MIXCOL_INV_EN defined) -> db 13 53 45, f2 0a 22 5c; undefined -> forward result.
REQ-029 Bench SHALL cover bypass: any state, bypass=1 -> data_out == data_in after 4 edges.
REQ-030 Bench SHALL cover backpressure: out_ready=0 for 10 cycles in DONE with in_valid=1 -> data_out stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-031 Bench SHALL cover reset: rst pulsed at 2nd BUSY cycle -> next cycle out_valid=0, data_out=0, in_ready=1; no out_valid pulse for the aborted state.
REQ-032 Bench SHALL cover back-to-back streaming: 8 random states with in_valid and out_ready held high -> outputs match a software model, one every 6 cycles.
